id_ex_stall_pipe: RTL
=====================

ID_EX_STALL_PIPE -- requirements
Module: id_ex_stall_pipe

Interface
REQ-001 Parameter MAX_STALL, default 3, SHALL give the consecutive-stall-cycle count at which the stall watchdog fires (legal range 1..15).
REQ-002 Parameter NOP_OPCODE, default 7'h00, SHALL give the opcode driven into ID/EX for a bubble.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 stall_ip  input  1  hazard stall request for the instruction currently in ID.
REQ-006 flush_ip  input  1  squash IF/ID and ID/EX (taken branch/jump).
REQ-007 IF_valid_ip  input  1  fetch stage presents a valid instruction.
REQ-008 IF_pc_ip  input  32  PC of the fetched instruction.
REQ-009 IF_instr_ip  input  32  fetched instruction word.
REQ-010 pc_write_en_op  output  1  PC register update enable.
REQ-011 ID_valid_op, ID_pc_op[31:0], ID_instr_op[31:0]  output  IF/ID register contents.
REQ-012 ID_instr_opcode_op[6:0], ID_src1_addr_op[4:0], ID_src2_addr_op[4:0]  output  fields of ID_instr_op: [6:0], [19:15], [24:20].
REQ-013 EX_valid_op  output  1, EX_pc_op  output  32, EX_instr_opcode_op  output  7, EX_reg_dest_op  output  5  ID/EX register contents.
REQ-014 stall_timeout_op  output  1  sticky watchdog error.

Function
REQ-015 The FSM SHALL have exactly two states: RUN and HOLD; it SHALL reset to RUN.
REQ-016 RUN->HOLD when stall_ip=1 and flush_ip=0; HOLD->RUN when stall_ip=0 or flush_ip=1; otherwise the state SHALL be kept.
REQ-017 pc_write_en_op SHALL be combinational: 1 when flush_ip=1 or stall_ip=0, else 0; it SHALL be 0 while reset=0.
REQ-018 The IF/ID register SHALL load IF_valid_ip/IF_pc_ip/IF_instr_ip on an edge with stall_ip=0 and flush_ip=0.
REQ-019 The IF/ID register SHALL keep its value on an edge with stall_ip=1 and flush_ip=0.
REQ-020 On an edge with flush_ip=1, ID_valid_op SHALL become 0 and ID_instr_op SHALL become 32'h0; flush SHALL take priority over stall.
REQ-021 On an edge with stall_ip=0, flush_ip=0 and ID_valid_op=1, ID/EX SHALL load EX_valid_op=1, EX_pc_op=ID_pc_op, EX_instr_opcode_op=ID_instr_op[6:0], EX_reg_dest_op=ID_instr_op[11:7].
REQ-022 On an edge with stall_ip=1, flush_ip=1, or ID_valid_op=0, ID/EX SHALL load a bubble: EX_valid_op=0, EX_instr_opcode_op=NOP_OPCODE, EX_reg_dest_op=0, EX_pc_op=0.
REQ-023 The latency from IF inputs to the EX outputs SHALL be exactly 2 edges with no stall.
REQ-024 A 4-bit stall counter SHALL increment on each edge in HOLD with stall_ip=1, SHALL saturate at 15, and SHALL clear on any edge with stall_ip=0 or flush_ip=1.
REQ-025 stall_timeout_op SHALL be set on the edge where the counter reaches MAX_STALL; it SHALL stay 1 until reset.

Reset
REQ-026 With reset=0 at an edge: state=RUN, ID_valid_op=0, ID_pc_op=0, ID_instr_op=0, EX outputs=bubble per REQ-022, stall counter=0, stall_timeout_op=0, performance counter=0.
REQ-027 Reset SHALL override stall_ip and flush_ip; a reset asserted during HOLD SHALL return to RUN on that edge.

Configuration
REQ-028 With macro STALL_PERF_CNT_EN defined, there SHALL be an output bubble_count_op[31:0] that counts edges inserting a bubble per REQ-022 (reset excluded) and wraps from 32'hFFFFFFFF to 0.
REQ-029 With STALL_PERF_CNT_EN undefined, there SHALL be no port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 Straight line: reset, then instr 32'h00208033 at PC 0x100 with no stall -> after 2 edges EX_valid_op=1, EX_instr_opcode_op=7'h33, EX_reg_dest_op=0, EX_pc_op=0x100.
REQ-031 Load-use: stall_ip=1 for 1 cycle with 32'h00310133 in ID -> pc_write_en_op=0 that cycle, ID held, one bubble in EX, then EX_reg_dest_op=2.
REQ-032 Stall+flush same cycle -> flush wins: ID_valid_op=0, EX bubble, FSM in RUN, counter=0.
REQ-033 stall_ip held 3 cycles (MAX_STALL=3) -> stall_timeout_op=1 on the 3rd edge; it stays 1 after stall drops until reset=0.
REQ-034 Reset=0 mid-HOLD -> all outputs at the REQ-026 values on the next edge.
REQ-035 With STALL_PERF_CNT_EN: 5 stall edges + 2 flush edges -> bubble_count_op=7; preload near 32'hFFFFFFFF to check wrap to 0.

Source files
------------

// File: rtl/id_ex_stall_pipe.sv
// IF/ID and ID/EX pipeline registers with hazard stall, flush and a stall watchdog.
// Optional bubble performance counter enabled by macro STALL_PERF_CNT_EN.
//
// Ports:
//   clk, reset (sync, active-low)
//   stall_ip, flush_ip                      hazard stall / squash requests
//   IF_valid_ip, IF_pc_ip, IF_instr_ip      fetch stage bundle
//   pc_write_en_op                          PC update enable (combinational)
//   ID_*_op                                 IF/ID register contents and decoded fields
//   EX_*_op                                 ID/EX register contents
//   stall_timeout_op                        sticky watchdog error
//   bubble_count_op                         bubbles inserted (STALL_PERF_CNT_EN only)
module id_ex_stall_pipe #(
    parameter int         MAX_STALL  = 3,
    parameter logic [6:0] NOP_OPCODE = 7'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_ip,
    input  logic        flush_ip,
    input  logic        IF_valid_ip,
    input  logic [31:0] IF_pc_ip,
    input  logic [31:0] IF_instr_ip,
    output logic        pc_write_en_op,
    output logic        ID_valid_op,
    output logic [31:0] ID_pc_op,
    output logic [31:0] ID_instr_op,
    output logic [6:0]  ID_instr_opcode_op,
    output logic [4:0]  ID_src1_addr_op,
    output logic [4:0]  ID_src2_addr_op,
    output logic        EX_valid_op,
    output logic [31:0] EX_pc_op,
    output logic [6:0]  EX_instr_opcode_op,
    output logic [4:0]  EX_reg_dest_op,
    output logic        stall_timeout_op
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] bubble_count_op
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic [6:0]  r_ex_opcode;
    logic [4:0]  r_ex_rd;
    logic [3:0]  r_stall_cnt;
    logic [3:0]  w_stall_cnt_nxt;
    logic        r_timeout;
    logic        w_bubble;
    logic        w_hold;

    assign w_hold   = stall_ip & ~flush_ip;
    assign w_bubble = stall_ip | flush_ip | ~r_id_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_hold)  w_state_nxt = HOLD;
            HOLD:    if (!w_hold) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
        if (!reset) w_state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
    end

    // Every edge that holds ID counts toward the watchdog, including the
    // edge that enters HOLD, so N stalled edges give a count of N.
    always_comb begin
        w_stall_cnt_nxt = 4'd0;
        if (w_hold) begin
            w_stall_cnt_nxt = (r_stall_cnt == 4'hF) ? 4'hF : r_stall_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_id_valid  <= 1'b0;
            r_id_pc     <= 32'h0;
            r_id_instr  <= 32'h0;
            r_ex_valid  <= 1'b0;
            r_ex_pc     <= 32'h0;
            r_ex_opcode <= NOP_OPCODE;
            r_ex_rd     <= 5'd0;
            r_stall_cnt <= 4'd0;
            r_timeout   <= 1'b0;
        end else begin
            if (flush_ip) begin
                r_id_valid <= 1'b0;
                r_id_instr <= 32'h0;
            end else if (!stall_ip) begin
                r_id_valid <= IF_valid_ip;
                r_id_pc    <= IF_pc_ip;
                r_id_instr <= IF_instr_ip;
            end
            if (w_bubble) begin
                r_ex_valid  <= 1'b0;
                r_ex_pc     <= 32'h0;
                r_ex_opcode <= NOP_OPCODE;
                r_ex_rd     <= 5'd0;
            end else begin
                r_ex_valid  <= 1'b1;
                r_ex_pc     <= r_id_pc;
                r_ex_opcode <= r_id_instr[6:0];
                r_ex_rd     <= r_id_instr[11:7];
            end
            r_stall_cnt <= w_stall_cnt_nxt;
            if (w_hold && w_stall_cnt_nxt == 4'(MAX_STALL)) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bubble_cnt <= 32'h0;
        end else if (w_bubble) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_count_op = r_bubble_cnt;
`endif

    assign pc_write_en_op     = reset & (flush_ip | ~stall_ip);
    assign ID_valid_op        = r_id_valid;
    assign ID_pc_op           = r_id_pc;
    assign ID_instr_op        = r_id_instr;
    assign ID_instr_opcode_op = r_id_instr[6:0];
    assign ID_src1_addr_op    = r_id_instr[19:15];
    assign ID_src2_addr_op    = r_id_instr[24:20];
    assign EX_valid_op        = r_ex_valid;
    assign EX_pc_op           = r_ex_pc;
    assign EX_instr_opcode_op = r_ex_opcode;
    assign EX_reg_dest_op     = r_ex_rd;
    assign stall_timeout_op   = r_timeout;

endmodule
